// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - OBI N:1 arbiter with round-robin selection and in-order response routing
// Optional macro OBI_ARB_FIXED_PRIO_EN: replaces round-robin with fixed priority (master 0 highest).
module obi_rr_arbiter #(
    parameter int NM      = 2,
    parameter int MAX_OUT = 2,
    localparam int IW     = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NM-1:0]     m_req_i,
    output logic [NM-1:0]     m_gnt_o,
    output logic [NM-1:0]     m_rvalid_o,
    input  logic [NM-1:0]     m_we_i,
    input  logic [4*NM-1:0]   m_be_i,
    input  logic [32*NM-1:0]  m_addr_i,
    input  logic [32*NM-1:0]  m_wdata_i,
    output logic [31:0]       m_rdata_o,
    output logic              s_req_o,
    input  logic              s_gnt_i,
    input  logic              s_rvalid_i,
    output logic              s_we_o,
    output logic [3:0]        s_be_o,
    output logic [31:0]       s_addr_o,
    output logic [31:0]       s_wdata_o,
    input  logic [31:0]       s_rdata_i,
    output logic              spurious_o
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [IW-1:0] fifo_q [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          spurious_q;

    logic [IW-1:0] sel;
    logic [IW-1:0] sel_lo;
    logic          lo_found;
    logic          any_req;
    logic          can_issue;
    logic          push, pop;

    assign any_req   = |m_req_i;
    assign can_issue = (count_q < CW'(MAX_OUT)) | s_rvalid_i;
    assign s_req_o   = any_req & can_issue;
    assign push      = s_req_o & s_gnt_i;
    assign pop       = s_rvalid_i & (count_q != '0);

    // Lowest-indexed requester; also the wrap-around fallback for round-robin.
    always_comb begin
        sel_lo   = '0;
        lo_found = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (m_req_i[i] && !lo_found) begin
                sel_lo   = IW'(i);
                lo_found = 1'b1;
            end
        end
    end

`ifdef OBI_ARB_FIXED_PRIO_EN
    assign sel = sel_lo;
`else
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] sel_hi;
    logic          hi_found;

    // First requester at or above rr_ptr wins; otherwise wrap to the lowest one.
    always_comb begin
        sel_hi   = '0;
        hi_found = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (m_req_i[i] && !hi_found && (IW'(i) >= rr_ptr_q)) begin
                sel_hi   = IW'(i);
                hi_found = 1'b1;
            end
        end
    end

    assign sel = hi_found ? sel_hi : sel_lo;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (sel == IW'(NM - 1)) ? '0 : sel + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        m_gnt_o   = '0;
        for (int i = 0; i < NM; i++) begin
            if (any_req && (sel == IW'(i))) begin
                s_we_o     = m_we_i[i];
                s_be_o     = m_be_i[4*i +: 4];
                s_addr_o   = m_addr_i[32*i +: 32];
                s_wdata_o  = m_wdata_i[32*i +: 32];
                m_gnt_o[i] = push;
            end
        end
    end

    always_comb begin
        m_rvalid_o = '0;
        for (int i = 0; i < NM; i++) begin
            m_rvalid_o[i] = pop & (fifo_q[rd_ptr_q] == IW'(i));
        end
    end

    assign m_rdata_o  = s_rdata_i;
    assign spurious_o = spurious_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q         <= (MAX_OUT == 1) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (MAX_OUT == 1) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q    <= count_d;
            spurious_q <= s_rvalid_i & (count_q == '0);
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb/tb_obi_rr_arbiter.sv - directed self-checking bench for obi_rr_arbiter (NM=2, MAX_OUT=2)
module tb_obi_rr_arbiter;

    localparam int NM      = 2;
    localparam int MAX_OUT = 2;

`ifdef OBI_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_gnt;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_we;
    logic [4*NM-1:0]   m_be;
    logic [32*NM-1:0]  m_addr;
    logic [32*NM-1:0]  m_wdata;
    logic [31:0]       m_rdata;
    logic              s_req;
    logic              s_gnt;
    logic              s_rvalid;
    logic              s_we;
    logic [3:0]        s_be;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [31:0]       s_rdata;
    logic              spurious;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NM(NM), .MAX_OUT(MAX_OUT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m_req_i    (m_req),
        .m_gnt_o    (m_gnt),
        .m_rvalid_o (m_rvalid),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata),
        .spurious_o (spurious)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        m_req    = req;
        s_gnt    = gnt;
        s_rvalid = rv;
        s_rdata  = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        m_req    = '0;
        m_we     = '0;
        m_be     = 8'hFF;
        m_addr   = {32'h0000_0200, 32'h1000_0004};
        m_wdata  = {32'h5555_0001, 32'h5555_0000};
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;

        // Reset state
        @(negedge clk);
        check_eq("rst_gnt",      64'(m_gnt),    64'h0);
        check_eq("rst_rvalid",   64'(m_rvalid), 64'h0);
        check_eq("rst_sreq",     64'(s_req),    64'h0);
        check_eq("rst_spurious", 64'(spurious), 64'h0);
        check_eq("rst_saddr",    64'(s_addr),   64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single master 0 read, response one cycle later
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check_eq("t1_gnt",   64'(m_gnt),  64'h1);
        check_eq("t1_sreq",  64'(s_req),  64'h1);
        check_eq("t1_saddr", 64'(s_addr), 64'h1000_0004);
        check_eq("t1_swe",   64'(s_we),   64'h0);
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check_eq("t1_rvalid",   64'(m_rvalid), 64'h1);
        check_eq("t1_rdata",    64'(m_rdata),  64'hDEAD_BEEF);
        check_eq("t1_spurious", 64'(spurious), 64'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check_eq("t1_rvalid_off", 64'(m_rvalid), 64'h0);
        check_eq("t1_spurious2",  64'(spurious), 64'h0);

        // Both masters requesting continuously, zero-wait slave with 1-cycle response
        do_reset();
        m_addr = {32'h0000_0200, 32'h0000_0100};
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_eq("t2_gnt0",   64'(m_gnt),  64'h1);
        check_eq("t2_addr0",  64'(s_addr), 64'h100);
        check_eq("t2_rv0",    64'(m_rvalid), 64'h0);
        drive(2'b11, 1'b1, 1'b1, 32'hA1);
        check_eq("t2_gnt1",   64'(m_gnt),  FIXED ? 64'h1 : 64'h2);
        check_eq("t2_addr1",  64'(s_addr), FIXED ? 64'h100 : 64'h200);
        check_eq("t2_rv1",    64'(m_rvalid), 64'h1);
        drive(2'b11, 1'b1, 1'b1, 32'hA2);
        check_eq("t2_gnt2",   64'(m_gnt),    64'h1);
        check_eq("t2_rv2",    64'(m_rvalid), FIXED ? 64'h1 : 64'h2);
        check_eq("t2_rdata2", 64'(m_rdata),  64'hA2);
        drive(2'b11, 1'b1, 1'b1, 32'hA3);
        check_eq("t2_gnt3",   64'(m_gnt),    FIXED ? 64'h1 : 64'h2);
        check_eq("t2_rv3",    64'(m_rvalid), 64'h1);
        drive(2'b00, 1'b0, 1'b1, 32'hA4);
        check_eq("t2_gnt4",   64'(m_gnt),    64'h0);
        check_eq("t2_rv4",    64'(m_rvalid), FIXED ? 64'h1 : 64'h2);

        // Outstanding limit, then drain and a spurious response
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_eq("t3_sreq0", 64'(s_req), 64'h1);
        check_eq("t3_gnt0",  64'(m_gnt), 64'h1);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_eq("t3_gnt1",  64'(m_gnt), FIXED ? 64'h1 : 64'h2);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_eq("t3_sreq_full", 64'(s_req), 64'h0);
        check_eq("t3_gnt_full",  64'(m_gnt), 64'h0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check_eq("t3_sreq_full2", 64'(s_req), 64'h0);
        drive(2'b11, 1'b1, 1'b1, 32'h33);
        check_eq("t3_sreq_pop", 64'(s_req),    64'h1);
        check_eq("t3_gnt_pop",  64'(m_gnt),    64'h1);
        check_eq("t3_rv_pop",   64'(m_rvalid), 64'h1);
        check_eq("t3_rd_pop",   64'(m_rdata),  64'h33);
        drive(2'b00, 1'b0, 1'b1, 32'h44);
        check_eq("t3_rv2",   64'(m_rvalid), FIXED ? 64'h1 : 64'h2);
        check_eq("t3_sreq2", 64'(s_req),    64'h0);
        drive(2'b00, 1'b0, 1'b1, 32'h55);
        check_eq("t3_rv3", 64'(m_rvalid), 64'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h66);
        check_eq("t3_rv_spur",  64'(m_rvalid), 64'h0);
        check_eq("t3_spur_now", 64'(spurious), 64'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check_eq("t3_spur_pulse", 64'(spurious), 64'h1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check_eq("t3_spur_end", 64'(spurious), 64'h0);

        // Interleaved issue: master 1 (write) then master 0, responses in issue order
        do_reset();
        m_we    = 2'b10;
        m_be    = 8'hC3;
        m_wdata = {32'hCAFE_F00D, 32'h1234_5678};
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check_eq("t4_gnt0",   64'(m_gnt),   64'h2);
        check_eq("t4_swe",    64'(s_we),    64'h1);
        check_eq("t4_sbe",    64'(s_be),    64'hC);
        check_eq("t4_swdata", 64'(s_wdata), 64'hCAFE_F00D);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check_eq("t4_gnt1", 64'(m_gnt), 64'h1);
        check_eq("t4_sbe1", 64'(s_be),  64'h3);
        drive(2'b00, 1'b0, 1'b1, 32'h11);
        check_eq("t4_rv0", 64'(m_rvalid), 64'h2);
        check_eq("t4_rd0", 64'(m_rdata),  64'h11);
        drive(2'b00, 1'b0, 1'b1, 32'h22);
        check_eq("t4_rv1", 64'(m_rvalid), 64'h1);
        check_eq("t4_rd1", 64'(m_rdata),  64'h22);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check_eq("t4_idle_sreq", 64'(s_req),  64'h0);
        check_eq("t4_idle_addr", 64'(s_addr), 64'h0);

        // Asynchronous reset with two transactions outstanding
        do_reset();
        m_we = '0;
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check_eq("t5_gnt_second", 64'(m_gnt), 64'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_req = '0;
        s_gnt = 1'b0;
        #1;
        check_eq("t5_rst_sreq",   64'(s_req),    64'h0);
        check_eq("t5_rst_gnt",    64'(m_gnt),    64'h0);
        check_eq("t5_rst_rvalid", 64'(m_rvalid), 64'h0);
        check_eq("t5_rst_spur",   64'(spurious), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h77);
        check_eq("t5_late_rv", 64'(m_rvalid), 64'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check_eq("t5_late_spur", 64'(spurious), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
